conv_tile_feeder: RTL
=====================

Name: conv_tile_feeder

Overview:
- Producer side of the convolution-loop input handshake. Fetches one padded pixel tile per output tile from the input-feature-map SRAM, and the kernel weights once per frame from the weight SRAM. Drives pixel_row_array/weights_array and pulses pixel_ready/weight_ready.
- Holds the tile stable until the loop reports acc_valid, then advances over the image in row-major tile order.

Parameters:
- kx, 3, kernel width/height (odd); pad P = kx/2
- Pix, 3, output tile width
- Piy, 3, output tile height
- RES, 8, pixel/weight bit width
- Nif, 10, input feature maps
- IMG_W, 6, image width; must be a multiple of Pix
- IMG_H, 6, image height; must be a multiple of Piy

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; begin a frame (ignored unless IDLE)
- pix_rd_en  out  1  pixel SRAM read strobe
- pix_rd_addr  out  clog2(Nif*IMG_H*IMG_W)  addr = map*IMG_H*IMG_W + y*IMG_W + x
- pix_rd_data  in  RES  valid exactly 1 cycle after pix_rd_en
- w_rd_en  out  1  weight SRAM read strobe
- w_rd_addr  out  clog2(Nif*kx*kx)  addr = map*kx*kx + k
- w_rd_data  in  RES  valid 1 cycle after w_rd_en
- pixel_row_array  out  RES x [Nif][Piy+2P][Pix+2P]  padded tile (registered)
- weights_array  out  RES x [Nif][kx*kx]  kernels (registered)
- pixel_ready  out  1  one-cycle pulse: tile valid
- weight_ready  out  1  one-cycle pulse, coincident with pixel_ready
- acc_valid  in  1  from conv loop: tile's accumulation complete
- tile_x  out  clog2(IMG_W/Pix)  current tile column
- tile_y  out  clog2(IMG_H/Piy)  current tile row
- busy  out  1  high whenever state != IDLE
- frame_done  out  1  one-cycle pulse after the last tile's acc_valid

Behaviour:
- Reset, asynchronous and active-high: state=IDLE. All arrays, addresses, strobes, ready pulses, tile_x/tile_y and frame_done are 0.
- FSM states: IDLE, LOAD_W, LOAD_P, ISSUE, WAIT.
- IDLE: on start, go to LOAD_W with tile_x=tile_y=0.
- LOAD_W: issues one read per cycle for k over 0..Nif*kx*kx-1, map-major. Each datum is written to weights_array[map][k] one cycle after its issue, through a registered destination index. Leaves after the last issue; the final write lands on the first LOAD_P cycle.
- LOAD_P: visits one element per cycle, Nif*(Piy+2P)*(Pix+2P) cycles, order map, then row r, then column c.
  - x = tile_x*Pix + c - P; y = tile_y*Piy + r - P.
  - Out of range (x<0, x>=IMG_W, y<0 or y>=IMG_H): pix_rd_en=0 and the element is written 0 in the same pipeline slot.
  - In range: read issued; data written to [map][r][c] one cycle later.
- ISSUE: one cycle after the last LOAD_P element, so the final write has landed. pixel_ready=weight_ready=1 for exactly this cycle. Next state is WAIT.
- WAIT: arrays held constant. On acc_valid:
  - If this is the last tile, pulse frame_done next cycle and go to IDLE.
  - Otherwise advance tile_x, wrapping to 0 and incrementing tile_y, then go to LOAD_P.
  - Weights are not reloaded within a frame.
- acc_valid outside WAIT is ignored. start while busy is ignored.
- Only one read strobe is active per cycle. pix_rd_en and w_rd_en are never high together.
- Latency: start to first pixel_ready is Nif*kx*kx + Nif*(Piy+2P)*(Pix+2P) + 2 cycles. acc_valid to the next pixel_ready is Nif*(Piy+2P)*(Pix+2P) + 2 cycles.
- Reset mid-load or mid-WAIT: everything clears immediately; no ready pulse follows until a new start.

Decomposition:
- Package conv_pkg: localparams PAD=kx/2, TW=Pix+2*PAD, TH=Piy+2*PAD, TILES_X=IMG_W/Pix, TILES_Y=IMG_H/Piy. Also the FSM state enum and a pixel_t typedef of logic [RES-1:0].
- Sub-module tile_addr_gen: holds the map/r/c counters and computes x/y, in-range flag, SRAM address and the last-element flag. The top module holds the FSM, the data pipeline and the arrays.

Test Plan:
Common setup: Nif=2, kx=3, Pix=Piy=3, IMG 6x6. SRAMs return data = addr[7:0].
- Weight load: start -> 18 w_rd_en cycles at addr 0..17; weights_array[1][8]=17; first pixel_ready 18+50+2=70 cycles after start.
- Tile (0,0):
  - pixel_row_array[m][0][*]=0 and [m][*][0]=0 (padding).
  - [0][1][1]=0, [1][1][1]=36, [0][3][3]=14, [0][4][4]=21.
  - Exactly 32 pix_rd_en pulses.
- Tile (1,0), after acc_valid:
  - tile_x=1; [0][1][0]=2, [0][1][3]=5, [0][1][4]=0 (x=6, out of range).
  - pixel_ready exactly 52 cycles after acc_valid.
- Full frame: 4 ready pulses, tile order (0,0),(1,0),(0,1),(1,1). frame_done pulses once, one cycle after the 4th acc_valid. busy then drops.
- Spurious inputs: acc_valid during LOAD_P and start during WAIT -> no state, counter or array change.
- Reset mid-LOAD_P: rst asserted asynchronously -> arrays 0, busy=0, no ready pulse. A new start restarts from weight address 0.

Source files
------------

// File: rtl/conv_tile_feeder_pkg.sv
// Shared types and default geometry for the convolution tile feeder.
// Modules recompute derived sizes from their own parameters; these are the defaults.
package conv_pkg;
   localparam int KX    = 3;
   localparam int PIX   = 3;
   localparam int PIY   = 3;
   localparam int RES   = 8;
   localparam int NIF   = 10;
   localparam int IMG_W = 6;
   localparam int IMG_H = 6;

   localparam int PAD     = KX / 2;
   localparam int TW      = PIX + 2 * PAD;
   localparam int TH      = PIY + 2 * PAD;
   localparam int TILES_X = IMG_W / PIX;
   localparam int TILES_Y = IMG_H / PIY;

   typedef logic [RES-1:0] pixel_t;

   typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_P, ISSUE, WAIT} state_t;

   // Counter width that never collapses to zero bits.
   function automatic int cw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/conv_tile_feeder_if.sv
// SRAM read ports plus the tile/weight handshake towards the convolution loop.
interface conv_tile_feeder_if #(
   parameter int Nif   = conv_pkg::NIF,
   parameter int kx    = conv_pkg::KX,
   parameter int Pix   = conv_pkg::PIX,
   parameter int Piy   = conv_pkg::PIY,
   parameter int RES   = conv_pkg::RES,
   parameter int IMG_W = conv_pkg::IMG_W,
   parameter int IMG_H = conv_pkg::IMG_H
);
   localparam int PAD = kx / 2;
   localparam int TW  = Pix + 2 * PAD;
   localparam int TH  = Piy + 2 * PAD;
   localparam int KK  = kx * kx;
   localparam int PAW = conv_pkg::cw(Nif * IMG_H * IMG_W);
   localparam int WAW = conv_pkg::cw(Nif * KK);
   localparam int TXW = conv_pkg::cw(IMG_W / Pix);
   localparam int TYW = conv_pkg::cw(IMG_H / Piy);

   logic                                   pix_rd_en;
   logic [PAW-1:0]                         pix_rd_addr;
   logic [RES-1:0]                         pix_rd_data;
   logic                                   w_rd_en;
   logic [WAW-1:0]                         w_rd_addr;
   logic [RES-1:0]                         w_rd_data;
   logic [Nif-1:0][TH-1:0][TW-1:0][RES-1:0] pixel_row_array;
   logic [Nif-1:0][KK-1:0][RES-1:0]        weights_array;
   logic                                   pixel_ready;
   logic                                   weight_ready;
   logic                                   acc_valid;
   logic [TXW-1:0]                         tile_x;
   logic [TYW-1:0]                         tile_y;

   modport master (
      output pix_rd_en, pix_rd_addr, w_rd_en, w_rd_addr,
      output pixel_row_array, weights_array, pixel_ready, weight_ready, tile_x, tile_y,
      input  pix_rd_data, w_rd_data, acc_valid
   );
   modport slave (
      input  pix_rd_en, pix_rd_addr, w_rd_en, w_rd_addr,
      input  pixel_row_array, weights_array, pixel_ready, weight_ready, tile_x, tile_y,
      output pix_rd_data, w_rd_data, acc_valid
   );
endinterface

// File: rtl/conv_tile_feeder_addr_gen.sv
// Walks map/row/column of the padded tile and maps each element to an SRAM address.
module tile_addr_gen #(
   parameter int Nif   = conv_pkg::NIF,
   parameter int kx    = conv_pkg::KX,
   parameter int Pix   = conv_pkg::PIX,
   parameter int Piy   = conv_pkg::PIY,
   parameter int IMG_W = conv_pkg::IMG_W,
   parameter int IMG_H = conv_pkg::IMG_H,
   localparam int PAD  = kx / 2,
   localparam int TW   = Pix + 2 * PAD,
   localparam int TH   = Piy + 2 * PAD,
   localparam int MW   = conv_pkg::cw(Nif),
   localparam int RW   = conv_pkg::cw(TH),
   localparam int CW   = conv_pkg::cw(TW),
   localparam int PAW  = conv_pkg::cw(Nif * IMG_H * IMG_W),
   localparam int TXW  = conv_pkg::cw(IMG_W / Pix),
   localparam int TYW  = conv_pkg::cw(IMG_H / Piy)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           step,
   input  logic [TXW-1:0] tile_x,
   input  logic [TYW-1:0] tile_y,
   output logic [MW-1:0]  map,
   output logic [RW-1:0]  r,
   output logic [CW-1:0]  c,
   output logic           in_range,
   output logic [PAW-1:0] addr,
   output logic           last
);
   int xs, ys;

   // Counters wrap to zero after the last element, so every tile starts clean.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         map <= '0;
         r   <= '0;
         c   <= '0;
      end else if (step) begin
         if (c == CW'(TW - 1)) begin
            c <= '0;
            if (r == RW'(TH - 1)) begin
               r   <= '0;
               map <= last ? '0 : map + 1'b1;
            end else begin
               r <= r + 1'b1;
            end
         end else begin
            c <= c + 1'b1;
         end
      end
   end

   always_comb begin
      xs       = int'(tile_x) * Pix + int'(c) - PAD;
      ys       = int'(tile_y) * Piy + int'(r) - PAD;
      in_range = (xs >= 0) && (xs < IMG_W) && (ys >= 0) && (ys < IMG_H);
      addr     = PAW'(int'(map) * IMG_H * IMG_W + ys * IMG_W + xs);
      last     = (map == MW'(Nif - 1)) && (r == RW'(TH - 1)) && (c == CW'(TW - 1));
   end
endmodule

// File: rtl/conv_tile_feeder.sv
// Loads kernels once per frame and one padded tile per output tile, then
// holds the tile until the convolution loop reports acc_valid.
module conv_tile_feeder import conv_pkg::*; #(
   parameter int Nif   = conv_pkg::NIF,
   parameter int kx    = conv_pkg::KX,
   parameter int Pix   = conv_pkg::PIX,
   parameter int Piy   = conv_pkg::PIY,
   parameter int RES   = conv_pkg::RES,
   parameter int IMG_W = conv_pkg::IMG_W,
   parameter int IMG_H = conv_pkg::IMG_H
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic busy,
   output logic frame_done,
   conv_tile_feeder_if.master bus
);
   localparam int PD  = kx / 2;
   localparam int TWD = Pix + 2 * PD;
   localparam int THT = Piy + 2 * PD;
   localparam int KK  = kx * kx;
   localparam int TX  = IMG_W / Pix;
   localparam int TY  = IMG_H / Piy;
   localparam int MW  = cw(Nif);
   localparam int RW  = cw(THT);
   localparam int CW  = cw(TWD);
   localparam int KW  = cw(KK);
   localparam int PAW = cw(Nif * IMG_H * IMG_W);
   localparam int WAW = cw(Nif * KK);
   localparam int TXW = cw(TX);
   localparam int TYW = cw(TY);

   state_t         state;
   logic [TXW-1:0] tile_x;
   logic [TYW-1:0] tile_y;
   logic [MW-1:0]  wmap;
   logic [KW-1:0]  wk;
   logic           w_last, tile_last;
   logic           pixel_ready, weight_ready;

   logic [MW-1:0]  gmap;
   logic [RW-1:0]  gr;
   logic [CW-1:0]  gc;
   logic           in_range, p_last;
   logic [PAW-1:0] gaddr;

   logic           wr_vld, wr_is_w, wr_zero;
   logic [MW-1:0]  wr_map;
   logic [RW-1:0]  wr_r;
   logic [CW-1:0]  wr_c;
   logic [KW-1:0]  wr_k;
   logic [Nif-1:0][THT-1:0][TWD-1:0][RES-1:0] pix_arr;
   logic [Nif-1:0][KK-1:0][RES-1:0]           w_arr;

   tile_addr_gen #(
      .Nif(Nif), .kx(kx), .Pix(Pix), .Piy(Piy), .IMG_W(IMG_W), .IMG_H(IMG_H)
   ) u_addr (
      .clk(clk), .rst(rst), .step(state == LOAD_P),
      .tile_x(tile_x), .tile_y(tile_y),
      .map(gmap), .r(gr), .c(gc),
      .in_range(in_range), .addr(gaddr), .last(p_last)
   );

   assign w_last    = (wmap == MW'(Nif - 1)) && (wk == KW'(KK - 1));
   assign tile_last = (tile_x == TXW'(TX - 1)) && (tile_y == TYW'(TY - 1));

   assign busy                = (state != IDLE);
   assign bus.w_rd_en         = (state == LOAD_W);
   assign bus.w_rd_addr       = bus.w_rd_en ? WAW'(int'(wmap) * KK + int'(wk)) : '0;
   assign bus.pix_rd_en       = (state == LOAD_P) && in_range;
   assign bus.pix_rd_addr     = bus.pix_rd_en ? gaddr : '0;
   assign bus.tile_x          = tile_x;
   assign bus.tile_y          = tile_y;
   assign bus.pixel_ready     = pixel_ready;
   assign bus.weight_ready    = weight_ready;
   assign bus.pixel_row_array = pix_arr;
   assign bus.weights_array   = w_arr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         tile_x       <= '0;
         tile_y       <= '0;
         wmap         <= '0;
         wk           <= '0;
         pixel_ready  <= 1'b0;
         weight_ready <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         pixel_ready  <= 1'b0;
         weight_ready <= 1'b0;
         frame_done   <= 1'b0;
         case (state)
            IDLE: if (start) begin
               state  <= LOAD_W;
               tile_x <= '0;
               tile_y <= '0;
               wmap   <= '0;
               wk     <= '0;
            end
            LOAD_W: begin
               if (wk == KW'(KK - 1)) begin
                  wk   <= '0;
                  wmap <= w_last ? '0 : wmap + 1'b1;
               end else begin
                  wk <= wk + 1'b1;
               end
               if (w_last) state <= LOAD_P;
            end
            LOAD_P: if (p_last) state <= ISSUE;
            // Ready is registered here so it appears together with the last array write.
            ISSUE: begin
               pixel_ready  <= 1'b1;
               weight_ready <= 1'b1;
               state        <= WAIT;
            end
            WAIT: if (bus.acc_valid) begin
               if (tile_last) begin
                  frame_done <= 1'b1;
                  state      <= IDLE;
               end else begin
                  state <= LOAD_P;
                  if (tile_x == TXW'(TX - 1)) begin
                     tile_x <= '0;
                     tile_y <= tile_y + 1'b1;
                  end else begin
                     tile_x <= tile_x + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // One-slot write pipeline aligned with the SRAM's single-cycle read latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_vld  <= 1'b0;
         wr_is_w <= 1'b0;
         wr_zero <= 1'b0;
         wr_map  <= '0;
         wr_r    <= '0;
         wr_c    <= '0;
         wr_k    <= '0;
         pix_arr <= '0;
         w_arr   <= '0;
      end else begin
         wr_vld  <= (state == LOAD_W) || (state == LOAD_P);
         wr_is_w <= (state == LOAD_W);
         wr_zero <= !in_range;
         wr_map  <= (state == LOAD_W) ? wmap : gmap;
         wr_r    <= gr;
         wr_c    <= gc;
         wr_k    <= wk;
         if (wr_vld) begin
            if (wr_is_w) w_arr[wr_map][wr_k] <= bus.w_rd_data;
            else         pix_arr[wr_map][wr_r][wr_c] <= wr_zero ? '0 : bus.pix_rd_data;
         end
      end
   end
endmodule
